// File: rtl/nonogram_pkg.sv
// Shared constants and sequencer state encoding for the nonogram line-solver front end.
package nonogram_pkg;

  localparam int unsigned SIZE   = 11;
  localparam int unsigned AMNT_W = 7;
  localparam int unsigned LINE_W = 5;

  typedef enum logic [2:0] {
    StIdle,
    StIndex,
    StOpt,
    StDrain,
    StLineEnd,
    StPassEnd,
    StDone,
    StStall
  } seq_state_t;

endpackage

// File: rtl/option_ring.sv
// Circular option buffer: one push and one pop per cycle, with occupancy tracking.
module option_ring #(
  parameter int unsigned Width = 11,
  parameter int unsigned Depth = 512
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    do_pop  = pop_i && !empty_o;
    // A full buffer still accepts a push when a pop frees a slot in the same cycle.
    do_push = push_i && (!full_o || do_pop);
    head_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/line_option_sequencer.sv
// Streams each line's surviving options to the line solver, writes kept options back and
// repeats passes until the solver reports solved or a pass removes nothing.
module line_option_sequencer #(
  parameter int unsigned SIZE   = 11,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned AMNT_W = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       num_rows,
  input  logic [3:0]                       num_cols,
  input  logic                             load_valid,
  input  logic [SIZE-1:0]                  load_option,
  input  logic                             amnt_we,
  input  logic [4:0]                       amnt_line,
  input  logic [AMNT_W-1:0]                amnt_val,
  input  logic                             start,
  output logic                             solver_started,
  output logic [SIZE-1:0]                  option_out,
  output logic                             option_valid,
  output logic [2*SIZE-1:0][AMNT_W-1:0]    old_options_amnt,
  input  logic                             ret_valid,
  input  logic                             put_back,
  input  logic                             solved,
  output logic                             done,
  output logic                             stalled,
  output logic                             overflow
);

  import nonogram_pkg::*;

  localparam int unsigned     NumLines = 2 * SIZE;
  localparam logic [4:0]      LastLine = 5'(NumLines - 1);
  localparam logic [LINE_W-1:0] MaxDim = LINE_W'(SIZE);
  localparam logic [AMNT_W-1:0] AmntMax = '1;

  seq_state_t                       state_q;
  logic [NumLines-1:0][AMNT_W-1:0]  amnt_q;
  logic [LINE_W-1:0]                line_q, num_lines_q;
  logic [AMNT_W-1:0]                remaining_q, new_cnt_q;
  logic                             pass_changed_q;
  logic [SIZE-1:0]                  option_q, ret_word_q;
  logic                             option_valid_q, opt_is_word_q, ret_window_q;
  logic                             solver_started_q, done_q, stalled_q, overflow_q;

  logic                             idle_like, load_accept, ret_accept, ret_push;
  logic                             ring_push, ring_pop, ring_full, ring_empty;
  logic [SIZE-1:0]                  ring_push_data, ring_head;
  logic [AMNT_W-1:0]                cur_amnt;
  logic [LINE_W-1:0]                rows_eff, cols_eff, start_lines;

  always_comb begin
    idle_like   = (state_q == StIdle) || (state_q == StDone) || (state_q == StStall);
    load_accept = idle_like && load_valid && !ring_full;
    // Only the cycle right after an option word is a valid verdict slot.
    ret_accept  = ret_window_q && ret_valid;
    ret_push    = ret_accept && put_back;
    ring_push      = ret_push || load_accept;
    ring_push_data = ret_push ? ret_word_q : load_option;
    cur_amnt    = amnt_q[line_q];
    ring_pop    = !ring_empty &&
                  (((state_q == StIndex) && (cur_amnt != '0)) ||
                   ((state_q == StOpt) && (remaining_q != '0)));
    rows_eff    = ({1'b0, num_rows} > MaxDim) ? MaxDim : {1'b0, num_rows};
    cols_eff    = ({1'b0, num_cols} > MaxDim) ? MaxDim : {1'b0, num_cols};
    start_lines = rows_eff + cols_eff;
  end

  option_ring #(
    .Width (SIZE),
    .Depth (DEPTH)
  ) u_ring (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (ring_push),
    .push_data_i (ring_push_data),
    .pop_i       (ring_pop),
    .head_o      (ring_head),
    .full_o      (ring_full),
    .empty_o     (ring_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      amnt_q           <= '0;
      line_q           <= '0;
      num_lines_q      <= '0;
      remaining_q      <= '0;
      new_cnt_q        <= '0;
      pass_changed_q   <= 1'b0;
      option_q         <= '0;
      ret_word_q       <= '0;
      option_valid_q   <= 1'b0;
      opt_is_word_q    <= 1'b0;
      ret_window_q     <= 1'b0;
      solver_started_q <= 1'b0;
      done_q           <= 1'b0;
      stalled_q        <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      solver_started_q <= 1'b0;
      option_valid_q   <= 1'b0;
      opt_is_word_q    <= 1'b0;
      ret_window_q     <= option_valid_q && opt_is_word_q;
      ret_word_q       <= option_q;

      if (ret_accept) begin
        if (put_back) new_cnt_q <= (new_cnt_q == AmntMax) ? AmntMax : new_cnt_q + AMNT_W'(1);
        else          pass_changed_q <= 1'b1;
      end
      if (idle_like && load_valid && ring_full) overflow_q <= 1'b1;

      unique case (state_q)
        StIdle, StDone, StStall: begin
          if (amnt_we && (amnt_line <= LastLine)) amnt_q[amnt_line] <= amnt_val;
          if (start) begin
            num_lines_q      <= start_lines;
            line_q           <= '0;
            pass_changed_q   <= 1'b0;
            done_q           <= 1'b0;
            stalled_q        <= 1'b0;
            solver_started_q <= 1'b1;
            new_cnt_q        <= '0;
            if (start_lines == '0) begin
              state_q <= StPassEnd;
            end else begin
              state_q        <= StIndex;
              option_q       <= '0;
              option_valid_q <= 1'b1;
            end
          end
        end
        StIndex: begin
          if (cur_amnt == '0) begin
            state_q <= StLineEnd;
          end else begin
            state_q        <= StOpt;
            option_q       <= ring_head;
            option_valid_q <= 1'b1;
            opt_is_word_q  <= 1'b1;
            remaining_q    <= cur_amnt - AMNT_W'(1);
          end
        end
        StOpt: begin
          if (remaining_q != '0) begin
            option_q       <= ring_head;
            option_valid_q <= 1'b1;
            opt_is_word_q  <= 1'b1;
            remaining_q    <= remaining_q - AMNT_W'(1);
          end else begin
            state_q <= StDrain;
          end
        end
        StDrain: state_q <= StLineEnd;
        StLineEnd: begin
          amnt_q[line_q] <= new_cnt_q;
          if (line_q + LINE_W'(1) == num_lines_q) begin
            state_q <= StPassEnd;
          end else begin
            line_q         <= line_q + LINE_W'(1);
            state_q        <= StIndex;
            option_q       <= SIZE'(line_q + LINE_W'(1));
            option_valid_q <= 1'b1;
            new_cnt_q      <= '0;
          end
        end
        StPassEnd: begin
          if (solved) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else if (!pass_changed_q) begin
            state_q   <= StStall;
            stalled_q <= 1'b1;
          end else begin
            pass_changed_q <= 1'b0;
            line_q         <= '0;
            new_cnt_q      <= '0;
            if (num_lines_q == '0) begin
              state_q <= StPassEnd;
            end else begin
              state_q        <= StIndex;
              option_q       <= '0;
              option_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    solver_started   = solver_started_q;
    option_out       = option_q;
    option_valid     = option_valid_q;
    old_options_amnt = amnt_q;
    done             = done_q;
    stalled          = stalled_q;
    overflow         = overflow_q;
  end

endmodule

// File: tb/tb_line_option_sequencer.sv
// Scoreboard bench for line_option_sequencer: expected stream queued at stimulus time,
// compared as words appear, verdicts returned one cycle after each option.
module tb_line_option_sequencer;

  localparam int unsigned SIZE   = 11;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned AMNT_W = 7;
  localparam int unsigned NL     = 2 * SIZE;

  typedef logic [NL-1:0][AMNT_W-1:0] amnt_t;
  typedef struct {
    logic [SIZE-1:0] word;
    bit              send;
    bit              keep;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        num_rows, num_cols;
  logic              load_valid;
  logic [SIZE-1:0]   load_option;
  logic              amnt_we;
  logic [4:0]        amnt_line;
  logic [AMNT_W-1:0] amnt_val;
  logic              start;
  logic              solver_started;
  logic [SIZE-1:0]   option_out;
  logic              option_valid;
  amnt_t             old_options_amnt;
  logic              ret_valid, put_back, solved;
  logic              done, stalled, overflow;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   started_cnt = 0;
  bit   pend_rv = 0, pend_pb = 0, stray_rv = 0, stray_pb = 0;

  always #5 clk = ~clk;

  line_option_sequencer #(
    .SIZE   (SIZE),
    .DEPTH  (DEPTH),
    .AMNT_W (AMNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .num_rows         (num_rows),
    .num_cols         (num_cols),
    .load_valid       (load_valid),
    .load_option      (load_option),
    .amnt_we          (amnt_we),
    .amnt_line        (amnt_line),
    .amnt_val         (amnt_val),
    .start            (start),
    .solver_started   (solver_started),
    .option_out       (option_out),
    .option_valid     (option_valid),
    .old_options_amnt (old_options_amnt),
    .ret_valid        (ret_valid),
    .put_back         (put_back),
    .solved           (solved),
    .done             (done),
    .stalled          (stalled),
    .overflow         (overflow)
  );

  function automatic amnt_t mk_amnt(input int a0, a1, a2, a3, a4, a5);
    amnt_t m = '0;
    m[0] = AMNT_W'(a0); m[1] = AMNT_W'(a1); m[2] = AMNT_W'(a2);
    m[3] = AMNT_W'(a3); m[4] = AMNT_W'(a4); m[5] = AMNT_W'(a5);
    return m;
  endfunction

  // One cycle: drive the verdict owed for last cycle's word, then score this cycle's word.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    ret_valid = pend_rv | stray_rv;
    put_back  = pend_rv ? pend_pb : stray_pb;
    pend_rv   = 0;
    pend_pb   = 0;
    if (solver_started) started_cnt++;
    if (option_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h, none expected", option_out);
      end else begin
        e = exp_q.pop_front();
        if (option_out !== e.word) begin
          errors++;
          $display("FAIL stream_word: got %h, expected %h", option_out, e.word);
        end
        pend_rv = e.send;
        pend_pb = e.keep;
      end
    end
  endtask

  task automatic push_idx(input int n, input bit stray);
    exp_q.push_back('{word: SIZE'(n), send: stray, keep: 1'b0});
  endtask

  task automatic push_opt(input logic [SIZE-1:0] w, input bit keep);
    exp_q.push_back('{word: w, send: 1'b1, keep: keep});
  endtask

  task automatic load_word(input logic [SIZE-1:0] w);
    load_valid = 1; load_option = w; tick(); load_valid = 0;
  endtask

  task automatic set_amnt(input int line, input int val);
    amnt_we = 1; amnt_line = 5'(line); amnt_val = AMNT_W'(val); tick(); amnt_we = 0;
  endtask

  task automatic do_start(input int rows, input int cols);
    num_rows = 4'(rows); num_cols = 4'(cols); start = 1; tick(); start = 0;
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", tag, exp_q.size(),
               budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++;
    if ({solver_started, option_valid, done, stalled, overflow} !== 5'b0 || option_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%b v=%b d=%b s=%b o=%b out=%h, expected all 0",
               solver_started, option_valid, done, stalled, overflow, option_out);
    end
    checks++;
    if (old_options_amnt !== '0 || dut.u_ring.count_q !== '0) begin
      errors++;
      $display("FAIL reset_state: amnt=%h occ=%0d, expected 0/0", old_options_amnt,
               dut.u_ring.count_q);
    end
    rst = 0; tick();
  endtask

  task automatic test_first_pass();
    logic [2:0] ws [12] = '{3'b110, 3'b011, 3'b100, 3'b010, 3'b001, 3'b101,
                            3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001};
    int cnt [6] = '{2, 3, 1, 1, 2, 3};
    for (int i = 0; i < 12; i++) load_word(SIZE'(ws[i]));
    for (int i = 0; i < 6; i++) set_amnt(i, cnt[i]);
    checks++;
    if (dut.u_ring.count_q !== 12) begin
      errors++;
      $display("FAIL load_occupancy: got %0d, expected 12", dut.u_ring.count_q);
    end
    push_idx(0, 0); push_opt(11'b110, 1); push_opt(11'b011, 1);
    push_idx(1, 0); push_opt(11'b100, 0); push_opt(11'b010, 1); push_opt(11'b001, 0);
    push_idx(2, 0); push_opt(11'b101, 1);
    push_idx(3, 0); push_opt(11'b101, 1);
    push_idx(4, 0); push_opt(11'b110, 0); push_opt(11'b011, 1);
    push_idx(5, 0); push_opt(11'b100, 1); push_opt(11'b010, 0); push_opt(11'b001, 0);
    started_cnt = 0;
    do_start(3, 3);
    run_until_empty(100, "first_pass");
    checks++;
    if (started_cnt !== 1) begin
      errors++;
      $display("FAIL solver_started_pulses: got %0d, expected 1", started_cnt);
    end
  endtask

  // Second pass keeps everything; stray verdicts behind index words must not count as drops.
  task automatic test_stall();
    int n = 0;
    push_idx(0, 1); push_opt(11'b110, 1); push_opt(11'b011, 1);
    push_idx(1, 1); push_opt(11'b010, 1);
    push_idx(2, 1); push_opt(11'b101, 1);
    push_idx(3, 1); push_opt(11'b101, 1);
    push_idx(4, 1); push_opt(11'b011, 1);
    push_idx(5, 1); push_opt(11'b100, 1);
    while (exp_q.size() == 13 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (old_options_amnt !== mk_amnt(2, 1, 1, 1, 1, 1)) begin
      errors++;
      $display("FAIL pass1_counts: got %h, expected %h", old_options_amnt,
               mk_amnt(2, 1, 1, 1, 1, 1));
    end
    run_until_empty(100, "second_pass");
    repeat (4) tick();
    checks++;
    if (stalled !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL stall_flags: got stalled=%b done=%b, expected 1/0", stalled, done);
    end
    repeat (10) tick();
    checks++;
    if (dut.u_ring.count_q !== 7 || old_options_amnt !== mk_amnt(2, 1, 1, 1, 1, 1)) begin
      errors++;
      $display("FAIL stall_state: occ=%0d amnt=%h, expected 7 and %h", dut.u_ring.count_q,
               old_options_amnt, mk_amnt(2, 1, 1, 1, 1, 1));
    end
  endtask

  task automatic test_zero_line_and_done();
    set_amnt(1, 0);
    set_amnt(2, 2);
    push_idx(0, 0); push_opt(11'b110, 1); push_opt(11'b011, 1);
    push_idx(1, 1);
    push_idx(2, 0); push_opt(11'b010, 1); push_opt(11'b101, 1);
    push_idx(3, 0); push_opt(11'b101, 1);
    push_idx(4, 0); push_opt(11'b011, 1);
    push_idx(5, 0); push_opt(11'b100, 0);
    solved = 1;
    do_start(3, 3);
    checks++;
    if (stalled !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears_stall: got %b, expected 0", stalled);
    end
    run_until_empty(100, "zero_line_pass");
    repeat (4) tick();
    solved = 0;
    checks++;
    if (done !== 1'b1 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: got done=%b stalled=%b, expected 1/0", done, stalled);
    end
    checks++;
    if (old_options_amnt !== mk_amnt(2, 0, 2, 1, 1, 0)) begin
      errors++;
      $display("FAIL zero_line_counts: got %h, expected %h", old_options_amnt,
               mk_amnt(2, 0, 2, 1, 1, 0));
    end
  endtask

  task automatic test_done_ignores_verdicts();
    stray_rv = 1; stray_pb = 0;
    repeat (5) tick();
    stray_pb = 1;
    repeat (5) tick();
    stray_rv = 0; stray_pb = 0;
    tick();
    checks++;
    if (done !== 1'b1 || dut.u_ring.count_q !== 6 ||
        old_options_amnt !== mk_amnt(2, 0, 2, 1, 1, 0)) begin
      errors++;
      $display("FAIL done_ignores_ret: done=%b occ=%0d amnt=%h, expected 1, 6, %h", done,
               dut.u_ring.count_q, old_options_amnt, mk_amnt(2, 0, 2, 1, 1, 0));
    end
  endtask

  task automatic test_overflow_and_reset();
    rst = 1; tick(); rst = 0; tick();
    load_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      load_option = SIZE'(i);
      tick();
    end
    load_valid = 0;
    checks++;
    if (overflow !== 1'b0 || dut.u_ring.count_q !== DEPTH) begin
      errors++;
      $display("FAIL fill_to_depth: overflow=%b occ=%0d, expected 0/%0d", overflow,
               dut.u_ring.count_q, DEPTH);
    end
    load_word(11'h7ff);
    checks++;
    if (overflow !== 1'b1 || dut.u_ring.count_q !== DEPTH) begin
      errors++;
      $display("FAIL overflow: overflow=%b occ=%0d, expected 1/%0d", overflow,
               dut.u_ring.count_q, DEPTH);
    end
    set_amnt(0, 5);
    push_idx(0, 0); push_opt(11'h000, 1);
    do_start(1, 0);
    run_until_empty(10, "pre_reset");
    rst = 1;
    #1;
    checks++;
    if ({solver_started, option_valid, done, stalled, overflow} !== 5'b0 || option_out !== '0 ||
        old_options_amnt !== '0) begin
      errors++;
      $display("FAIL mid_opt_reset_outputs: st=%b v=%b d=%b s=%b o=%b out=%h amnt=%h, expected 0",
               solver_started, option_valid, done, stalled, overflow, option_out,
               old_options_amnt);
    end
    checks++;
    if (dut.u_ring.wr_ptr_q !== '0 || dut.u_ring.rd_ptr_q !== '0 || dut.u_ring.count_q !== '0)
    begin
      errors++;
      $display("FAIL mid_opt_reset_ptrs: wr=%0d rd=%0d occ=%0d, expected 0/0/0",
               dut.u_ring.wr_ptr_q, dut.u_ring.rd_ptr_q, dut.u_ring.count_q);
    end
    exp_q.delete();
    pend_rv = 0; pend_pb = 0;
    tick();
    rst = 0;
    tick();
  endtask

  // Restart after reset: one-row board, drop in pass 1, all kept in pass 2, then stall.
  task automatic test_back_to_back();
    load_word(11'h0a1); load_word(11'h152); load_word(11'h2f3);
    set_amnt(0, 3);
    push_idx(0, 0); push_opt(11'h0a1, 1); push_opt(11'h152, 0); push_opt(11'h2f3, 1);
    push_idx(0, 0); push_opt(11'h0a1, 1); push_opt(11'h2f3, 1);
    started_cnt = 0;
    do_start(1, 0);
    run_until_empty(60, "back_to_back");
    repeat (4) tick();
    checks++;
    if (stalled !== 1'b1 || old_options_amnt !== mk_amnt(2, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL b2b_stall: stalled=%b amnt=%h, expected 1 and %h", stalled,
               old_options_amnt, mk_amnt(2, 0, 0, 0, 0, 0));
    end
    checks++;
    if (started_cnt !== 1 || dut.u_ring.count_q !== 2) begin
      errors++;
      $display("FAIL b2b_misc: started=%0d occ=%0d, expected 1/2", started_cnt,
               dut.u_ring.count_q);
    end
  endtask

  initial begin
    rst = 1; num_rows = 0; num_cols = 0; load_valid = 0; load_option = '0;
    amnt_we = 0; amnt_line = '0; amnt_val = '0; start = 0;
    ret_valid = 0; put_back = 0; solved = 0;
    test_reset();
    test_first_pass();
    test_stall();
    test_zero_line_and_done();
    test_done_ignores_verdicts();
    test_overflow_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_option_sequencer.md
Name: line_option_sequencer

Overview:
- Upstream feeder for the line solver: stores every candidate option of every row/column in a circular option buffer.
- Streams one line at a time into the solver as a line-index word followed by that line's surviving options.
- Writes back each option the solver keeps (put-back) and maintains the per-line option counts the solver consumes.
- Runs repeated passes over all lines until the solver reports solved, or until a full pass removes nothing (stall).

Parameters:
- SIZE, 11, maximum board dimension; option word width in bits.
- DEPTH, 512, option buffer entries; power of two.
- AMNT_W, 7, width of a per-line option count.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- num_rows  in  4  active rows, sampled when start is asserted
- num_cols  in  4  active columns, sampled when start is asserted
- load_valid  in  1  load one option word into the buffer tail
- load_option  in  SIZE  option bits, LSB = cell 0
- amnt_we  in  1  write initial count for one line
- amnt_line  in  5  line number for amnt_we: rows first, then columns
- amnt_val  in  AMNT_W  initial option count for that line
- start  in  1  one-cycle pulse: begin solving
- solver_started  out  1  one-cycle pulse to the solver
- option_out  out  SIZE  word to solver: line index (zero-extended) or option
- option_valid  out  1  option_out valid this cycle
- old_options_amnt  out  (2*SIZE)*AMNT_W  per-line counts for the current pass, packed [2*SIZE-1:0][AMNT_W-1:0]
- ret_valid  in  1  solver verdict valid
- put_back  in  1  with ret_valid: keep the option
- solved  in  1  solver reports board fully known
- done  out  1  level; solved observed at a pass end
- stalled  out  1  level; full pass with no count change
- overflow  out  1  sticky; load attempted while buffer full

Behaviour:
- Reset: state IDLE; all outputs 0; pointers 0; occupancy 0; counts 0.
- Loading in IDLE:
  - Each load_valid pushes load_option at the write pointer.
  - When occupancy == DEPTH, the word is dropped and overflow is set.
  - amnt_we writes old_options_amnt[amnt_line].
- start in IDLE: latch num_rows/num_cols, set L = rows+cols, line=0, pass_changed=0; assert solver_started for 1 cycle; go INDEX.
- INDEX (1 cycle): option_out = line, option_valid=1, new_cnt=0, remaining = old_options_amnt[line].
  - remaining == 0 -> LINE_END; else -> OPT.
- OPT: one option per cycle from the read pointer; the read pointer advances and occupancy decrements on each pop.
  - After the last option -> DRAIN.
- Return path:
  - Fixed latency: ret_valid arrives exactly 1 cycle after the matching option_valid.
  - put_back=1: push the popped word (held in a 1-deep return register) to the write pointer; new_cnt++.
  - put_back=0: word discarded; pass_changed=1.
  - Simultaneous pop and push in the same cycle is legal; occupancy is unchanged.
- DRAIN (1 cycle): waits for the last verdict.
- LINE_END: old_options_amnt[line] <= new_cnt; line++; at line == L -> PASS_END, else INDEX.
- PASS_END (sampled in this cycle):
  - solved=1 -> DONE, regardless of pass_changed.
  - Else pass_changed=0 -> STALL.
  - Else clear pass_changed, line=0, -> INDEX.
- DONE/STALL: hold done/stalled high. The next start re-enters from IDLE semantics without clearing the buffer. Only rst clears the buffer.
- Robustness:
  - ret_valid outside the 1-cycle window is ignored.
  - Counts saturate at 2^AMNT_W-1.
  - Pointers wrap modulo DEPTH.
- rst mid-pass: immediate return to reset state; buffer contents are lost.

Decomposition:
- Shared package nonogram_pkg: SIZE, AMNT_W, LINE_W=5, state enum seq_state_t {IDLE,INDEX,OPT,DRAIN,LINE_END,PASS_END,DONE,STALL}.
- One sub-module: option_ring. DEPTH x SIZE circular buffer with independent push/pop in the same cycle and occupancy/full/empty flags.

Test Plan:
- 3x3 board (rows 110; 010; 101). Load 12 options, counts {2,3,1,1,2,3}, start -> first stream is 0,110,011,1,100,010,001,2,101,3,101,4,110,011,5,100,010,001. solver_started pulses once.
- Pass with verdicts keeping only 110/011(row0), 010(row1), 101, 101, 011(col1), 100(col2) -> next-pass counts {2,1,1,1,1,1}. Second stream emits exactly those words in the same order.
- Line with count 0 -> only its index word is emitted; its count stays 0.
- Pass where every verdict is put_back=1 and solved=0 -> stalled=1 after PASS_END; option_valid stays 0 thereafter.
- solved=1 at PASS_END -> done=1; subsequent ret_valid is ignored.
- Load DEPTH+1 words -> overflow=1, occupancy=DEPTH. rst mid-OPT -> all outputs 0 on the same edge and the pointers are cleared.
